posit_mult_arbiter: RTL and testbench

Shares one pipelined 32-bit posit multiplier (positmult_4: 4-cycle latency, no backpressure, no reset) between NREQ requesters. Round-robin arbitration issues at most one operation per cycle. Each operation is tagged with its requester ID in a shift pipeline aligned to the multiplier latency. Results are steered into per-requester response FIFOs, and per-requester credit counters guarantee those FIFOs never overflow.

---
 rtl/posit_mult_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_posit_mult_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_arbiter.sv
// ---------------------------------------------------------------------------
// posit_mult_arbiter
//
// Shares one pipelined 32-bit posit multiplier (fixed latency LAT, no
// backpressure, no reset) among NREQ requesters. A round-robin arbiter issues
// at most one operation per cycle. A {valid, id} tag pipe travels alongside
// the multiplier so each result can be steered into its requester's response
// FIFO. Per-requester credits stop a requester being granted when its FIFO
// could overflow. After reset a drain window ignores whatever the unreset
// multiplier still has in flight.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     per-requester request handshake (ready is one-hot/0)
//   req_a, req_b        operands, requester i at [32i+31:32i]
//   rsp_valid/ready     per-requester response handshake
//   rsp_data/inf/zero   FIFO head per requester (product, NaR flag, zero flag)
//   mult_in1/in2/start  registered multiplier issue interface
//   mult_result/inf/    multiplier outputs, valid when mult_done is high
//   mult_zero/done
//   err_tag             sticky: mult_done disagreed with the tag pipe
// ---------------------------------------------------------------------------
module posit_mult_arbiter #(
    parameter int NREQ  = 4,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_data,
    output logic [NREQ-1:0]      rsp_inf,
    output logic [NREQ-1:0]      rsp_zero,
    output logic [31:0]          mult_in1,
    output logic [31:0]          mult_in2,
    output logic                 mult_start,
    input  logic [31:0]          mult_result,
    input  logic                 mult_inf,
    input  logic                 mult_zero,
    input  logic                 mult_done,
    output logic                 err_tag
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int DW  = $clog2(LAT + 2);
    localparam logic [CW-1:0] CREDIT_MAX   = CW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_CYCLES = DW'(LAT + 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic        inf;
        logic        zero;
        logic [31:0] data;
    } rsp_t;

    // Arbitration and drain
    logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
    logic           draining;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;

    // Issue registers and tag pipe
    logic [31:0] mult_in1_q, mult_in1_d;
    logic [31:0] mult_in2_q, mult_in2_d;
    logic        mult_start_q, mult_start_d;
    tag_t        tag_q [LAT+1];
    tag_t        tag_d [LAT+1];
    logic        err_tag_q, err_tag_d;

    // Writeback, credits and response FIFOs
    logic            wb_en;
    rsp_t            wb_entry;
    logic [NREQ-1:0] push, pop;
    logic [CW-1:0]   credit_q [NREQ];
    logic [CW-1:0]   credit_d [NREQ];
    logic [CW-1:0]   cnt_q    [NREQ];
    logic [CW-1:0]   cnt_d    [NREQ];
    logic [AW-1:0]   wr_ptr_q [NREQ];
    logic [AW-1:0]   wr_ptr_d [NREQ];
    logic [AW-1:0]   rd_ptr_q [NREQ];
    logic [AW-1:0]   rd_ptr_d [NREQ];
    rsp_t            mem_q    [NREQ][DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign draining = (drain_cnt_q != '0);

    // -----------------------------------------------------------------------
    // Eligibility, round-robin grant, pointer and drain counter
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any conditional logic so no latch is inferred.
        eligible    = '0;
        grant       = '0;
        grant_vld   = 1'b0;
        grant_id    = '0;
        cand        = '0;
        ptr_d       = ptr_q;
        drain_cnt_d = draining ? drain_cnt_q - 1'b1 : drain_cnt_q;

        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (credit_q[i] != '0) && !draining;
        end

        // Scan upward from the pointer, wrapping, and take the first eligible index.
        for (int off = 0; off < NREQ; off++) begin
            cand = ((int'(ptr_q) + off) >= NREQ) ? IDW'(int'(ptr_q) + off - NREQ)
                                                 : IDW'(int'(ptr_q) + off);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end

        if (grant_vld) begin
            grant[grant_id] = 1'b1;
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Issue, tag pipe, writeback and alignment check
    // -----------------------------------------------------------------------
    always_comb begin
        mult_in1_d   = mult_in1_q;
        mult_in2_d   = mult_in2_q;
        mult_start_d = grant_vld;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mult_in1_d = req_a[32*i +: 32];
                mult_in2_d = req_b[32*i +: 32];
            end
        end

        // Stage 0 loads with mult_start, so stage LAT lines up with mult_done.
        tag_d[0] = '{vld: grant_vld, id: grant_id};
        for (int s = 1; s <= LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        wb_en    = mult_done && tag_q[LAT].vld && !draining;
        wb_entry = '{inf: mult_inf, zero: mult_zero, data: mult_result};

        // During drain the multiplier may still emit pre-reset results.
        err_tag_d = err_tag_q || (!draining && (mult_done != tag_q[LAT].vld));
    end

    // -----------------------------------------------------------------------
    // Credits and FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < NREQ; i++) begin
            push[i] = wb_en && (tag_q[LAT].id == IDW'(i));
            pop[i]  = rsp_ready[i] && (cnt_q[i] != '0);

            credit_d[i] = credit_q[i];
            if (grant[i] && !pop[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end else if (pop[i] && !grant[i]) begin
                credit_d[i] = credit_q[i] + 1'b1;
            end

            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (pop[i] && !push[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end

            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            drain_cnt_q  <= DRAIN_CYCLES;
            ptr_q        <= '0;
            mult_in1_q   <= '0;
            mult_in2_q   <= '0;
            mult_start_q <= 1'b0;
            err_tag_q    <= 1'b0;
            for (int s = 0; s <= LAT; s++) begin
                tag_q[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= CREDIT_MAX;
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            drain_cnt_q  <= drain_cnt_d;
            ptr_q        <= ptr_d;
            mult_in1_q   <= mult_in1_d;
            mult_in2_q   <= mult_in2_d;
            mult_start_q <= mult_start_d;
            err_tag_q    <= err_tag_d;
            tag_q        <= tag_d;
            credit_q     <= credit_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy counters alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= wb_entry;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i]         = (cnt_q[i] != '0);
            rsp_data[32*i +: 32] = mem_q[i][rd_ptr_q[i]].data;
            rsp_inf[i]           = mem_q[i][rd_ptr_q[i]].inf;
            rsp_zero[i]          = mem_q[i][rd_ptr_q[i]].zero;
        end
    end

    assign req_ready  = grant;
    assign mult_in1   = mult_in1_q;
    assign mult_in2   = mult_in2_q;
    assign mult_start = mult_start_q;
    assign err_tag    = err_tag_q;

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_posit_mult_arbiter
//
// Bench for posit_mult_arbiter. A behavioural posit32 (es=2) multiplier with
// fixed latency stands in for positmult_4; it handles zero, NaR and signed
// powers of two, which is all the stimulus uses. A monitor keeps a
// transaction-level reference (per-requester queues of expected responses with
// their due cycle, a round-robin pointer, a drain countdown, a sticky error
// flag) and compares the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_posit_mult_arbiter;
    localparam int NREQ  = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] NAR   = 32'h8000_0000;
    localparam logic [31:0] P_ONE = 32'h4000_0000;
    localparam logic [31:0] P_TWO = 32'h4800_0000;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [32*NREQ-1:0]  rsp_data;
    logic [NREQ-1:0]     rsp_inf;
    logic [NREQ-1:0]     rsp_zero;
    logic [31:0]         mult_in1;
    logic [31:0]         mult_in2;
    logic                mult_start;
    logic [31:0]         mult_result;
    logic                mult_inf;
    logic                mult_zero;
    logic                mult_done;
    logic                err_tag;
    logic                force_done;

    int n_checks = 0;
    int n_fail   = 0;

    posit_mult_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_inf    (rsp_inf),
        .rsp_zero   (rsp_zero),
        .mult_in1   (mult_in1),
        .mult_in2   (mult_in2),
        .mult_start (mult_start),
        .mult_result(mult_result),
        .mult_inf   (mult_inf),
        .mult_zero  (mult_zero),
        .mult_done  (mult_done),
        .err_tag    (err_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- posit32 es=2 helpers ----------------
    // Encodes +2^k.
    function automatic logic [31:0] enc(input int k);
        logic [31:0] p;
        int r, e, pos;
        p   = '0;
        r   = (k >= 0) ? k / 4 : -((-k + 3) / 4);
        e   = k - 4 * r;
        pos = 30;
        if (r >= 0) begin
            for (int i = 0; i <= r; i++) begin
                p[pos] = 1'b1;
                pos--;
            end
            pos--;
        end else begin
            pos = pos + r;
            p[pos] = 1'b1;
            pos--;
        end
        p[pos]   = (e >= 2);
        p[pos-1] = (e % 2 == 1);
        return p;
    endfunction

    function automatic int kdec(input logic [31:0] x);
        for (int k = -40; k <= 40; k++) begin
            if (enc(k) == x) return k;
        end
        return 0;
    endfunction

    // Returns {inf, zero, product}.
    function automatic logic [33:0] pmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, m;
        if (a == NAR || b == NAR) return {2'b10, NAR};
        if (a == 32'd0 || b == 32'd0) return {2'b01, 32'd0};
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        m  = enc(kdec(ma) + kdec(mb));
        return {2'b00, (a[31] ^ b[31]) ? (~m + 32'd1) : m};
    endfunction

    function automatic logic [31:0] rand_operand();
        int sel;
        logic [31:0] p;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) return 32'd0;
        if (sel == 1) return NAR;
        p = enc(int'($urandom_range(0, 12)) - 6);
        return ($urandom_range(0, 3) == 0) ? (~p + 32'd1) : p;
    endfunction

    // ---------------- multiplier model (no reset, fixed latency) ----------------
    logic        mp_v [LAT];
    logic [31:0] mp_a [LAT];
    logic [31:0] mp_b [LAT];

    always @(posedge clk) begin
        mp_v[0] <= mult_start;
        mp_a[0] <= mult_in1;
        mp_b[0] <= mult_in2;
        for (int s = 1; s < LAT; s++) begin
            mp_v[s] <= mp_v[s-1];
            mp_a[s] <= mp_a[s-1];
            mp_b[s] <= mp_b[s-1];
        end
    end

    assign mult_done = mp_v[LAT-1] | force_done;
    assign {mult_inf, mult_zero, mult_result} = pmul(mp_a[LAT-1], mp_b[LAT-1]);

    // ---------------- reference model and monitor ----------------
    typedef struct {
        logic [33:0] rsp;
        int          due;
    } exp_t;

    exp_t exp_q [NREQ][$];
    int   gcnt  [NREQ];
    int   cyc = 0;

    initial begin
        int   m_ptr, m_drain, g, j;
        logic m_err, exp_v;
        logic [NREQ-1:0] exp_g;
        exp_t e;
        m_ptr = 0;
        m_drain = LAT + 1;
        m_err = 1'b0;
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                for (int i = 0; i < NREQ; i++) exp_q[i].delete();
                m_ptr   = 0;
                m_drain = LAT + 1;
                m_err   = 1'b0;
            end else begin
                // Arbitration: first requester at or after the pointer that
                // wants service and has fewer than DEPTH responses owed.
                g = -1;
                exp_g = '0;
                for (int off = 0; off < NREQ; off++) begin
                    j = (m_ptr + off) % NREQ;
                    if (g < 0 && m_drain == 0 && req_valid[j] && exp_q[j].size() < DEPTH) g = j;
                end
                if (g >= 0) exp_g[g] = 1'b1;
                check("req_ready", req_ready, exp_g);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) gcnt[i]++;
                end

                // Responses appear LAT+2 cycles after the grant, in order.
                for (int i = 0; i < NREQ; i++) begin
                    exp_v = (exp_q[i].size() != 0) && (exp_q[i][0].due <= cyc);
                    check($sformatf("rsp_valid[%0d]", i), rsp_valid[i], exp_v);
                    if (exp_v) begin
                        e = exp_q[i][0];
                        check($sformatf("rsp_data[%0d]", i), rsp_data[32*i +: 32], e.rsp[31:0]);
                        check($sformatf("rsp_inf_zero[%0d]", i), {rsp_inf[i], rsp_zero[i]}, e.rsp[33:32]);
                        if (rsp_ready[i]) void'(exp_q[i].pop_front());
                    end
                end

                if (g >= 0) begin
                    e.rsp = pmul(req_a[32*g +: 32], req_b[32*g +: 32]);
                    e.due = cyc + LAT + 2;
                    exp_q[g].push_back(e);
                    m_ptr = (g + 1) % NREQ;
                end

                check("err_tag", err_tag, m_err);
                if (force_done && m_drain == 0) m_err = 1'b1;
                if (m_drain > 0) m_drain--;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drain();
        for (int n = 0; n < LAT + 1; n++) begin
            @(negedge clk);
            check("drain_ready", req_ready, '0);
        end
        @(negedge clk);
        check("post_drain_grant", |req_ready, 1'b1);
    endtask

    task automatic directed_op(input int id, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_data, input logic exp_inf,
                               input logic exp_zero);
        int n;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid = oh;
        rsp_ready = '0;
        @(negedge clk);
        check("dir_grant", req_ready, oh);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("dir_start", mult_start, 1'b1);
        check("dir_in1", mult_in1, a);
        check("dir_in2", mult_in2, b);
        n = 1;
        while (!rsp_valid[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dir_latency", n, LAT + 2);
        check("dir_data", rsp_data[32*id +: 32], exp_data);
        check("dir_inf", rsp_inf[id], exp_inf);
        check("dir_zero", rsp_zero[id], exp_zero);
        tick();
        rsp_ready = '1;
        repeat (3) tick();
    endtask

    initial begin
        int base;
        reset      = 1'b1;
        req_valid  = '0;
        rsp_ready  = '1;
        force_done = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = P_ONE;
            req_b[32*i +: 32] = P_ONE;
        end
        repeat (6) tick();

        // Drain after power-up reset, with every requester asking.
        reset = 1'b0;
        req_valid = '1;
        check_drain();
        tick();
        req_valid = '0;
        repeat (12) tick();

        // Single op and special values.
        directed_op(0, P_ONE, P_TWO, P_TWO, 1'b0, 1'b0);
        directed_op(0, P_ONE, P_TWO, P_TWO, 1'b0, 1'b0);
        directed_op(2, 32'd0, P_TWO, 32'd0, 1'b0, 1'b1);
        directed_op(3, NAR, P_TWO, NAR, 1'b1, 1'b0);

        // Round-robin, all requesters continuously valid.
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = P_ONE;
            req_b[32*i +: 32] = (i % 2 == 1) ? P_TWO : P_ONE;
        end
        rsp_ready = '1;
        req_valid = '1;
        repeat (24) tick();
        req_valid = '0;
        repeat (12) tick();

        // Credit stall on requester 1.
        base = gcnt[1];
        rsp_ready[1] = 1'b0;
        req_valid = 4'b0010;
        repeat (12) tick();
        check("stall_grants", gcnt[1] - base, 4);
        check("stall_ready", req_ready[1], 1'b0);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        repeat (10) tick();
        check("stall_one_more", gcnt[1] - base, 5);
        req_valid = '0;
        rsp_ready = '1;
        repeat (15) tick();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                req_a[32*i +: 32] = rand_operand();
                req_b[32*i +: 32] = rand_operand();
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (20) tick();

        // Reset in the middle of three issues.
        req_valid = 4'b0111;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_drain();
        tick();
        req_valid = '0;
        repeat (12) tick();
        check("reset_err_tag", err_tag, 1'b0);

        // Spurious mult_done with nothing in flight.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        @(negedge clk);
        check("misalign_set", err_tag, 1'b1);
        repeat (5) tick();
        check("misalign_sticky", err_tag, 1'b1);
        check("misalign_no_write", rsp_valid, '0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared", err_tag, 1'b0);
        repeat (10) tick();

        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("owed_rsp[%0d]", i), exp_q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
